// File: rtl/ristretto_trap_pkg.sv
// Shared types for the trap control unit.
// Holds the trap code encodings, the selected-trap kind and cause, the TCU
// sequencer states and the cause -> mcause packing helper.
package ristretto_trap_pkg;

  typedef enum logic [1:0] {
    INSTR_NOTRAP        = 2'b00,
    INSTR_MISALIG_FETCH = 2'b01,
    INSTR_ILLEGAL_FETCH = 2'b10
  } instr_trap_e;

  typedef enum logic [1:0] {
    LSU_NOTRAP        = 2'b00,
    LSU_MISALIG_LOAD  = 2'b01,
    LSU_MISALIG_STORE = 2'b10
  } lsu_trap_e;

  typedef enum logic [1:0] {
    ENC_NOTRAP = 2'b00,
    ENC_ECALL  = 2'b01,
    ENC_MRET   = 2'b10
  } enc_trap_e;

  typedef enum logic [1:0] {
    TCU_NOTRAP    = 2'b00,
    TCU_INTERRUPT = 2'b01,
    TCU_EXCEPTION = 2'b10
  } tcu_kind_e;

  // bit4 flags an interrupt; bits[3:0] are the architectural cause code
  typedef enum logic [4:0] {
    CAUSE_MISALIG_FETCH = 5'h00,
    CAUSE_ILLEGAL_INSTR = 5'h02,
    CAUSE_MISALIG_LOAD  = 5'h04,
    CAUSE_MISALIG_STORE = 5'h06,
    CAUSE_ENV_CALL_MMODE = 5'h0b,
    CAUSE_MSW_INT       = 5'h13,
    CAUSE_MTIM_INT      = 5'h17,
    CAUSE_MEXT_INT      = 5'h1b
  } trap_cause_e;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SAVE,
    RESTORE,
    JUMP
  } tcu_state_e;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // Interrupt flag lands in the MSB of an xlen-wide mcause; callers slice
  // the low xlen bits of the 64-bit result.
  function automatic logic [63:0] cause_to_mcause(input logic [4:0] cause,
                                                  input int unsigned xlen = 32);
    return ({63'b0, cause[4]} << (xlen - 1)) | {60'b0, cause[3:0]};
  endfunction

endpackage

// File: rtl/ristretto_trap_ctrl_if.sv
// CSR write-back and fetch redirect port of the trap control unit.
// master (TCU): drives csr_save/csr_mret strobes, csr_mepc/mcause/mtval,
//               redirect_valid/redirect_pc; receives redirect_ready.
// slave (CSR file / fetch): the reverse.
interface ristretto_trap_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            csr_save_o;
  logic [XLEN-1:0] csr_mepc_o;
  logic [XLEN-1:0] csr_mcause_o;
  logic [XLEN-1:0] csr_mtval_o;
  logic            csr_mret_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            redirect_ready_i;

  modport master (
    output csr_save_o, csr_mepc_o, csr_mcause_o, csr_mtval_o, csr_mret_o,
    output redirect_valid_o, redirect_pc_o,
    input  redirect_ready_i
  );

  modport slave (
    input  csr_save_o, csr_mepc_o, csr_mcause_o, csr_mtval_o, csr_mret_o,
    input  redirect_valid_o, redirect_pc_o,
    output redirect_ready_i
  );
endinterface

// File: rtl/ristretto_trap_prio.sv
// Combinational trap selector.
// Inputs: commit valid, fetch/LSU/encoder trap codes, irq lines, MIE, mie.
// Outputs: take_o (something to act on), kind_o, cause_o, is_mret_o.
// Order: MEXT > MSW > MTIM > illegal fetch > misaligned fetch > ECALL >
// misaligned load > misaligned store > MRET. Code 2'b11 matches nothing.
module ristretto_trap_prio
  import ristretto_trap_pkg::*;
(
  input  logic        valid_i,
  input  logic [1:0]  instr_trap_i,
  input  logic [1:0]  lsu_trap_i,
  input  logic [1:0]  enc_trap_i,
  input  logic        irq_sw_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  input  logic        mstatus_mie_i,
  input  logic [2:0]  mie_i,
  output logic        take_o,
  output tcu_kind_e   kind_o,
  output trap_cause_e cause_o,
  output logic        is_mret_o
);
  logic w_ext, w_sw, w_tim;

  assign w_ext = mstatus_mie_i & irq_ext_i   & mie_i[2];
  assign w_sw  = mstatus_mie_i & irq_sw_i    & mie_i[0];
  assign w_tim = mstatus_mie_i & irq_timer_i & mie_i[1];

  always_comb begin
    take_o    = 1'b0;
    kind_o    = TCU_NOTRAP;
    cause_o   = CAUSE_MISALIG_FETCH;
    is_mret_o = 1'b0;
    if (valid_i) begin
      take_o = 1'b1;
      kind_o = TCU_EXCEPTION;
      if (w_ext) begin
        kind_o = TCU_INTERRUPT; cause_o = CAUSE_MEXT_INT;
      end else if (w_sw) begin
        kind_o = TCU_INTERRUPT; cause_o = CAUSE_MSW_INT;
      end else if (w_tim) begin
        kind_o = TCU_INTERRUPT; cause_o = CAUSE_MTIM_INT;
      end else if (instr_trap_i == INSTR_ILLEGAL_FETCH) begin
        cause_o = CAUSE_ILLEGAL_INSTR;
      end else if (instr_trap_i == INSTR_MISALIG_FETCH) begin
        cause_o = CAUSE_MISALIG_FETCH;
      end else if (enc_trap_i == ENC_ECALL) begin
        cause_o = CAUSE_ENV_CALL_MMODE;
      end else if (lsu_trap_i == LSU_MISALIG_LOAD) begin
        cause_o = CAUSE_MISALIG_LOAD;
      end else if (lsu_trap_i == LSU_MISALIG_STORE) begin
        cause_o = CAUSE_MISALIG_STORE;
      end else if (enc_trap_i == ENC_MRET) begin
        kind_o    = TCU_NOTRAP;
        is_mret_o = 1'b1;
      end else begin
        take_o = 1'b0;
        kind_o = TCU_NOTRAP;
      end
    end
  end
endmodule

// File: rtl/ristretto_trap_ctrl.sv
// Trap control unit sequencer.
// Plain ports: clk_i, rst_i (async, active high), commit-stage trap codes,
// trap_pc_i/trap_val_i, irq lines, mstatus_mie_i, mie_i, mtvec_i, mepc_i,
// stall_o, flush_o, tcu_kind_o.
// tcu_if (master): CSR save/mret strobes with mepc/mcause/mtval values and
// the fetch redirect valid/pc/ready handshake.
// Sequence: IDLE -> FLUSH -> SAVE|RESTORE -> JUMP (held until ready) -> IDLE.
module ristretto_trap_ctrl
  import ristretto_trap_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [1:0]      instr_trap_i,
  input  logic [1:0]      lsu_trap_i,
  input  logic [1:0]      enc_trap_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_val_i,
  input  logic            irq_sw_i,
  input  logic            irq_timer_i,
  input  logic            irq_ext_i,
  input  logic            mstatus_mie_i,
  input  logic [2:0]      mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            stall_o,
  output logic            flush_o,
  output logic [1:0]      tcu_kind_o,
  ristretto_trap_ctrl_if.master tcu_if
);
  tcu_state_e  r_state, w_next;
  tcu_kind_e   r_kind;
  trap_cause_e r_cause;
  logic        r_is_mret;
  logic [XLEN-1:0] r_pc, r_val, r_target;

  logic        w_take, w_is_mret;
  tcu_kind_e   w_kind;
  trap_cause_e w_cause;
  logic [XLEN-1:0] w_base, w_vec_off, w_target;
  logic [63:0]     w_mcause_full;

  ristretto_trap_prio u_prio (
    .valid_i       (valid_i),
    .instr_trap_i  (instr_trap_i),
    .lsu_trap_i    (lsu_trap_i),
    .enc_trap_i    (enc_trap_i),
    .irq_sw_i      (irq_sw_i),
    .irq_timer_i   (irq_timer_i),
    .irq_ext_i     (irq_ext_i),
    .mstatus_mie_i (mstatus_mie_i),
    .mie_i         (mie_i),
    .take_o        (w_take),
    .kind_o        (w_kind),
    .cause_o       (w_cause),
    .is_mret_o     (w_is_mret)
  );

  assign w_base    = {mtvec_i[XLEN-1:2], 2'b00};
  assign w_vec_off = {{(XLEN-6){1'b0}}, w_cause[3:0], 2'b00};
  assign w_target  = (VECTORED_EN && w_kind == TCU_INTERRUPT &&
                      mtvec_i[1:0] == MTVEC_MODE_VECTORED) ? w_base + w_vec_off : w_base;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Trap context is captured on the detection edge; MRET overwrites the
  // target with mepc_i while in RESTORE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_kind    <= TCU_NOTRAP;
      r_cause   <= CAUSE_MISALIG_FETCH;
      r_is_mret <= 1'b0;
      r_pc      <= '0;
      r_val     <= '0;
      r_target  <= '0;
    end else if (r_state == IDLE && w_take) begin
      r_kind    <= w_kind;
      r_cause   <= w_cause;
      r_is_mret <= w_is_mret;
      r_pc      <= trap_pc_i;
      r_val     <= (w_kind == TCU_EXCEPTION && w_cause != CAUSE_ENV_CALL_MMODE) ? trap_val_i : '0;
      r_target  <= w_target;
    end else if (r_state == RESTORE) begin
      r_target  <= mepc_i;
    end
  end

  always_comb begin
    w_next                  = r_state;
    stall_o                 = 1'b1;
    flush_o                 = 1'b0;
    tcu_if.csr_save_o       = 1'b0;
    tcu_if.csr_mret_o       = 1'b0;
    tcu_if.redirect_valid_o = 1'b0;
    unique case (r_state)
      IDLE: begin
        stall_o = 1'b0;
        if (w_take) w_next = FLUSH;
      end
      FLUSH: begin
        flush_o = 1'b1;
        w_next  = r_is_mret ? RESTORE : SAVE;
      end
      SAVE: begin
        tcu_if.csr_save_o = 1'b1;
        w_next            = JUMP;
      end
      RESTORE: begin
        tcu_if.csr_mret_o = 1'b1;
        w_next            = JUMP;
      end
      JUMP: begin
        tcu_if.redirect_valid_o = 1'b1;
        if (tcu_if.redirect_ready_i) w_next = IDLE;
      end
      default: begin
        stall_o = 1'b0;
        w_next  = IDLE;
      end
    endcase
  end

  assign w_mcause_full        = cause_to_mcause(r_cause, XLEN);
  assign tcu_kind_o           = (r_state == IDLE) ? TCU_NOTRAP : r_kind;
  assign tcu_if.csr_mepc_o    = r_pc;
  assign tcu_if.csr_mcause_o  = w_mcause_full[XLEN-1:0];
  assign tcu_if.csr_mtval_o   = r_val;
  assign tcu_if.redirect_pc_o = r_target;
endmodule

// File: tb/tb_ristretto_trap_ctrl.sv
// Self-checking bench for ristretto_trap_ctrl: a cycles-since-detection model
// checked every negedge, plus literal pins for each directed scenario.
module tb_ristretto_trap_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        valid;
  logic [1:0]  instr_trap, lsu_trap, enc_trap;
  logic [31:0] trap_pc, trap_val, mtvec, mepc;
  logic        irq_sw, irq_timer, irq_ext, mstatus_mie;
  logic [2:0]  mie;
  logic        stall_o, flush_o;
  logic [1:0]  tcu_kind_o;

  int checks = 0;
  int failures = 0;

  ristretto_trap_ctrl_if #(.XLEN(32)) tcu_if();

  ristretto_trap_ctrl #(.XLEN(32), .VECTORED_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid),
    .instr_trap_i(instr_trap), .lsu_trap_i(lsu_trap), .enc_trap_i(enc_trap),
    .trap_pc_i(trap_pc), .trap_val_i(trap_val),
    .irq_sw_i(irq_sw), .irq_timer_i(irq_timer), .irq_ext_i(irq_ext),
    .mstatus_mie_i(mstatus_mie), .mie_i(mie), .mtvec_i(mtvec), .mepc_i(mepc),
    .stall_o(stall_o), .flush_o(flush_o), .tcu_kind_o(tcu_kind_o),
    .tcu_if(tcu_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit          take;
    bit          mret;
    logic [1:0]  kind;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] target;
  } ev_t;

  function automatic ev_t model_eval();
    ev_t e;
    logic [31:0] base, code;
    e = '0;
    base = mtvec & 32'hFFFF_FFFC;
    if (valid !== 1'b1) return e;
    e.take = 1; e.mepc = trap_pc; e.kind = 2'd2; e.target = base;
    code = 32'hFFFF_FFFF;
    if (mstatus_mie) begin
      if (irq_ext && mie[2])        code = 11;
      else if (irq_sw && mie[0])    code = 3;
      else if (irq_timer && mie[1]) code = 7;
    end
    if (code != 32'hFFFF_FFFF) begin
      e.kind = 2'd1;
      e.mcause = 32'h8000_0000 + code;
      if (mtvec[1:0] == 2'b01) e.target = base + 4 * code;
    end
    else if (instr_trap == 2'd2) begin e.mcause = 2;  e.mtval = trap_val; end
    else if (instr_trap == 2'd1) begin e.mcause = 0;  e.mtval = trap_val; end
    else if (enc_trap == 2'd1)   begin e.mcause = 11; end
    else if (lsu_trap == 2'd1)   begin e.mcause = 4;  e.mtval = trap_val; end
    else if (lsu_trap == 2'd2)   begin e.mcause = 6;  e.mtval = trap_val; end
    else if (enc_trap == 2'd2)   begin e.mret = 1; e.kind = 2'd0; end
    else e.take = 0;
    return e;
  endfunction

  ev_t m_now, m_ev;
  int  m_cyc;  // cycles since detection edge; -1 = nothing in flight
  always_comb m_now = model_eval();

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc <= -1;
      m_ev  <= '0;
    end else if (m_cyc < 0) begin
      if (m_now.take) begin m_cyc <= 1; m_ev <= m_now; end
    end else if (m_cyc == 2) begin
      if (m_ev.mret) m_ev.target <= mepc;
      m_cyc <= 3;
    end else if (m_cyc >= 3) begin
      if (tcu_if.redirect_ready_i) m_cyc <= -1;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_stall", 32'(stall_o), 0);
      check("rst_flush", 32'(flush_o), 0);
      check("rst_kind", 32'(tcu_kind_o), 0);
      check("rst_save", 32'(tcu_if.csr_save_o), 0);
      check("rst_mret", 32'(tcu_if.csr_mret_o), 0);
      check("rst_rvalid", 32'(tcu_if.redirect_valid_o), 0);
      check("rst_rpc", tcu_if.redirect_pc_o, 0);
      check("rst_mepc", tcu_if.csr_mepc_o, 0);
      check("rst_mcause", tcu_if.csr_mcause_o, 0);
      check("rst_mtval", tcu_if.csr_mtval_o, 0);
    end else begin
      check("m_stall", 32'(stall_o), 32'(m_cyc >= 1));
      check("m_flush", 32'(flush_o), 32'(m_cyc == 1));
      check("m_save", 32'(tcu_if.csr_save_o), 32'(m_cyc == 2 && !m_ev.mret));
      check("m_mret", 32'(tcu_if.csr_mret_o), 32'(m_cyc == 2 && m_ev.mret));
      check("m_rvalid", 32'(tcu_if.redirect_valid_o), 32'(m_cyc >= 3));
      check("m_kind", 32'(tcu_kind_o), (m_cyc >= 1) ? 32'(m_ev.kind) : 0);
      if (m_cyc >= 3) check("m_rpc", tcu_if.redirect_pc_o, m_ev.target);
      if (m_cyc == 2 && !m_ev.mret) begin
        check("m_mepc", tcu_if.csr_mepc_o, m_ev.mepc);
        check("m_mcause", tcu_if.csr_mcause_o, m_ev.mcause);
        check("m_mtval", tcu_if.csr_mtval_o, m_ev.mtval);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    valid = 0; instr_trap = 0; lsu_trap = 0; enc_trap = 0;
    trap_pc = 0; trap_val = 0; irq_sw = 0; irq_timer = 0; irq_ext = 0;
    mstatus_mie = 0; mie = 3'b000; mtvec = 32'h8000; mepc = 0;
    tcu_if.redirect_ready_i = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (stall_o !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_idle_timeout"}, 32'(stall_o), 0);
    @(posedge clk); #1;
  endtask

  // Call at posedge+1 with inputs already set; pins flush/save/redirect timing.
  task automatic fire_and_pin(input string tag, input logic [31:0] e_mepc,
                              input logic [31:0] e_mcause, input logic [31:0] e_mtval,
                              input logic [31:0] e_target, input bit e_mret,
                              input logic [1:0] e_kind);
    valid = 1;
    @(posedge clk); #1;
    valid = 0;
    check({tag, "_flush"}, 32'(flush_o), 1);
    check({tag, "_kind"}, 32'(tcu_kind_o), 32'(e_kind));
    @(posedge clk); #1;
    check({tag, "_save"}, 32'(tcu_if.csr_save_o), 32'(!e_mret));
    check({tag, "_mret"}, 32'(tcu_if.csr_mret_o), 32'(e_mret));
    if (!e_mret) begin
      check({tag, "_mepc"}, tcu_if.csr_mepc_o, e_mepc);
      check({tag, "_mcause"}, tcu_if.csr_mcause_o, e_mcause);
      check({tag, "_mtval"}, tcu_if.csr_mtval_o, e_mtval);
    end
    @(posedge clk); #1;
    check({tag, "_rvalid"}, 32'(tcu_if.redirect_valid_o), 1);
    check({tag, "_rpc"}, tcu_if.redirect_pc_o, e_target);
    wait_idle(tag);
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", 32'(stall_o), 0);
    check("reset_kind", 32'(tcu_kind_o), 0);
    rst = 0;
    @(posedge clk); #1;

    // illegal instruction, direct vector
    instr_trap = 2'b10; trap_pc = 32'h100; trap_val = 32'hFFFF_FFFF; mtvec = 32'h8000;
    fire_and_pin("illegal", 32'h100, 32'h2, 32'hFFFF_FFFF, 32'h8000, 0, 2'd2);

    // vectored timer interrupt
    mtvec = 32'h8001; mstatus_mie = 1; mie = 3'b010; irq_timer = 1;
    trap_pc = 32'h200; trap_val = 32'h1234;
    fire_and_pin("vtimer", 32'h200, 32'h8000_0007, 32'h0, 32'h801C, 0, 2'd1);

    // ext + sw + load misaligned: ext wins
    mtvec = 32'h8001; mstatus_mie = 1; mie = 3'b101; irq_ext = 1; irq_sw = 1;
    lsu_trap = 2'b01; trap_pc = 32'h300; trap_val = 32'h55;
    fire_and_pin("ext_wins", 32'h300, 32'h8000_000B, 32'h0, 32'h802C, 0, 2'd1);

    // same with global MIE off: load misaligned
    mtvec = 32'h8001; mstatus_mie = 0; mie = 3'b101; irq_ext = 1; irq_sw = 1;
    lsu_trap = 2'b01; trap_pc = 32'h300; trap_val = 32'h55;
    fire_and_pin("load_mis", 32'h300, 32'h4, 32'h55, 32'h8000, 0, 2'd2);

    // sw beats timer
    mtvec = 32'h8001; mstatus_mie = 1; mie = 3'b011; irq_sw = 1; irq_timer = 1;
    trap_pc = 32'h340;
    fire_and_pin("sw_int", 32'h340, 32'h8000_0003, 32'h0, 32'h800C, 0, 2'd1);

    // MRET
    enc_trap = 2'b10; mepc = 32'h2040; trap_pc = 32'h380;
    fire_and_pin("mret", 32'h0, 32'h0, 32'h0, 32'h2040, 1, 2'd0);

    // ECALL + store misaligned: ECALL wins, mtval 0
    enc_trap = 2'b01; lsu_trap = 2'b10; trap_pc = 32'h3C0; trap_val = 32'h77; mtvec = 32'h9001;
    fire_and_pin("ecall", 32'h3C0, 32'hB, 32'h0, 32'h9000, 0, 2'd2);

    // MRET alongside fetch misalignment: exception taken
    enc_trap = 2'b10; instr_trap = 2'b01; trap_pc = 32'h3E0; trap_val = 32'h3E2; mepc = 32'h2040;
    fire_and_pin("mret_blk", 32'h3E0, 32'h0, 32'h3E2, 32'h8000, 0, 2'd2);

    // store misaligned alone
    lsu_trap = 2'b10; trap_pc = 32'h3F0; trap_val = 32'h1001;
    fire_and_pin("store_mis", 32'h3F0, 32'h6, 32'h1001, 32'h8000, 0, 2'd2);

    // 2'b11 codes mean no trap
    instr_trap = 2'b11; lsu_trap = 2'b11; enc_trap = 2'b11; valid = 1;
    @(posedge clk); #1;
    check("code11_stall", 32'(stall_o), 0);
    @(posedge clk); #1;
    check("code11_flush", 32'(flush_o), 0);
    clear_inputs();
    @(posedge clk); #1;

    // backpressure: redirect held, new irq ignored until accept
    tcu_if.redirect_ready_i = 0;
    instr_trap = 2'b10; trap_pc = 32'h400; trap_val = 32'hDEAD; mtvec = 32'h8000;
    valid = 1;
    @(posedge clk); #1;
    valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    instr_trap = 0; irq_ext = 1; mie = 3'b100; mstatus_mie = 1; valid = 1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid", 32'(tcu_if.redirect_valid_o), 1);
      check("bp_rpc", tcu_if.redirect_pc_o, 32'h8000);
      check("bp_stall", 32'(stall_o), 1);
      check("bp_kind", 32'(tcu_kind_o), 2);
      @(posedge clk); #1;
    end
    tcu_if.redirect_ready_i = 1;
    @(posedge clk); #1;
    check("bp_back_idle", 32'(stall_o), 0);
    @(posedge clk); #1;
    valid = 0;
    check("bp_irq_flush", 32'(flush_o), 1);
    check("bp_irq_kind", 32'(tcu_kind_o), 1);
    @(posedge clk); #1;
    check("bp_irq_mcause", tcu_if.csr_mcause_o, 32'h8000_000B);
    check("bp_irq_mepc", tcu_if.csr_mepc_o, 32'h400);
    wait_idle("bp");
    clear_inputs();

    // reset during SAVE aborts the sequence
    instr_trap = 2'b10; trap_pc = 32'h500; trap_val = 32'h1; valid = 1;
    @(posedge clk); #1;
    valid = 0;
    @(posedge clk); #1;
    check("rs_in_save", 32'(tcu_if.csr_save_o), 1);
    #2 rst = 1;
    #1;
    check("rs_save", 32'(tcu_if.csr_save_o), 0);
    check("rs_stall", 32'(stall_o), 0);
    check("rs_kind", 32'(tcu_kind_o), 0);
    check("rs_mepc", tcu_if.csr_mepc_o, 0);
    check("rs_rvalid", 32'(tcu_if.redirect_valid_o), 0);
    @(posedge clk); #1;
    rst = 0;
    instr_trap = 2'b10; enc_trap = 2'b01; irq_ext = 1; mstatus_mie = 1; mie = 3'b111; valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rs_novalid_stall", 32'(stall_o), 0);
      check("rs_novalid_save", 32'(tcu_if.csr_save_o), 0);
    end
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ristretto_trap_ctrl.md
Name: ristretto_trap_ctrl

Overview:
Trap control unit (TCU) sequencer for the RV32 core. It samples the trap codes of the committing instruction (fetch, LSU, encoder) and the machine interrupt lines, then selects one trap by priority. It runs a flush/save/redirect sequence that drives the CSR file and the fetch redirect port. MRET follows the same path and restores to mepc.

Parameters:
XLEN, 32, datapath/CSR width
VECTORED_EN, 1, 1 = honour mtvec.MODE==01 for interrupts; 0 = always direct

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous active-high reset
valid_i  in  1  instruction in commit stage is valid
instr_trap_i  in  2  INSTR_NOTRAP/INSTR_MISALIG_FETCH/INSTR_ILLEGAL_FETCH
lsu_trap_i  in  2  LSU_NOTRAP/LSU_MISALIG_LOAD/LSU_MISALIG_STORE
enc_trap_i  in  2  ENC_NOTRAP/ENC_ECALL/ENC_MRET
trap_pc_i  in  XLEN  PC of committing instruction
trap_val_i  in  XLEN  faulting address or instruction word
irq_sw_i, irq_timer_i, irq_ext_i  in  1 each  level-sensitive pending lines
mstatus_mie_i  in  1  global interrupt enable
mie_i  in  3  {MEIE, MTIE, MSIE}
mtvec_i  in  XLEN  trap vector (MODE in [1:0])
mepc_i  in  XLEN  current mepc, used by MRET
stall_o  out  1  hold pipeline; high in every non-IDLE state
flush_o  out  1  one-cycle pipeline flush
tcu_kind_o  out  2  TCU_NOTRAP/TCU_INTERRUPT/TCU_EXCEPTION of the trap in flight
csr_save_o  out  1  one-cycle strobe: write mepc/mcause/mtval, MPIE<=MIE, MIE<=0
csr_mepc_o, csr_mcause_o, csr_mtval_o  out  XLEN each  values written on csr_save_o
csr_mret_o  out  1  one-cycle strobe: MIE<=MPIE, MPIE<=1
redirect_valid_o  out  1  fetch redirect request
redirect_pc_o  out  XLEN  redirect target
redirect_ready_i  in  1  fetch accepts redirect

Behaviour:
- Reset: state IDLE. All outputs 0, including tcu_kind_o=TCU_NOTRAP. Internal cause/pc/val registers are cleared to 0. Reset asserted mid-sequence aborts it immediately; no strobe fires after reset.
- Event detection only in IDLE with valid_i=1. All inputs are ignored in other states because the pipeline is stalled/flushed.
- Interrupt taken if mstatus_mie_i & (irq_ext_i&mie_i[2] | irq_sw_i&mie_i[0] | irq_timer_i&mie_i[1]).
- Interrupt priority: MEXT_INT > MSW_INT > MTIM_INT.
- Interrupts beat any exception or MRET in the same cycle. The instruction is not committed and mepc = trap_pc_i.
- Exception priority: INSTR_ILLEGAL_FETCH > INSTR_MISALIG_FETCH > ENC_ECALL > LSU_MISALIG_LOAD > LSU_MISALIG_STORE.
- ENC_MRET is honoured only if no instruction trap is present. Encoding 2'b11 on any code input means no trap.
- Cause encoding: 5-bit enum, bit4 = interrupt flag. mcause = {cause[4], (XLEN-5)'b0, cause[3:0]}. ECALL reports ENV_CALL_MMODE (0x0b).
- mtval: trap_val_i for illegal, fetch-misaligned, load/store-misaligned; 0 for ECALL and interrupts.
- Target: interrupt with VECTORED_EN and mtvec_i[1:0]==01 -> {mtvec_i[XLEN-1:2],2'b00} + 4*cause[3:0]; otherwise {mtvec_i[XLEN-1:2],2'b00}. MRET target = mepc_i sampled in RESTORE.
- FSM states and transitions:
  - IDLE -> FLUSH on trap or MRET. Trap info is latched this cycle (cycle 0).
  - FLUSH (cycle 1): flush_o=1 -> SAVE (trap) or RESTORE (MRET).
  - SAVE (cycle 2): csr_save_o=1, csr_* outputs valid -> JUMP.
  - RESTORE (cycle 2): csr_mret_o=1; mepc_i is latched into the target -> JUMP.
  - JUMP (cycle 3+): redirect_valid_o=1 with redirect_pc_o stable until redirect_ready_i=1, then -> IDLE.
- Minimum latency from detection to redirect accept is 3 cycles. A new trap may be taken in the cycle after returning to IDLE.
- tcu_kind_o holds the kind from FLUSH through JUMP. It is TCU_NOTRAP in IDLE and during MRET.

Decomposition:
- Add to ristretto_trap_pkg:
  - tcu_state_e {IDLE, FLUSH, SAVE, RESTORE, JUMP}
  - function cause_to_mcause(logic[4:0])
  - constant MTVEC_MODE_VECTORED = 2'b01
- Sub-module ristretto_trap_prio: purely combinational. Outputs take, kind, cause and is_mret from the code/irq/enable inputs; the FSM stays in ristretto_trap_ctrl.

Test Plan:
- Illegal instr: instr_trap_i=10, trap_pc_i=0x100, trap_val_i=0xFFFFFFFF, mtvec_i=0x8000 -> flush at +1; at +2 csr_save_o with mepc=0x100, mcause=0x2, mtval=0xFFFFFFFF; redirect 0x8000 at +3.
- Vectored timer irq: mtvec_i=0x8001, MIE=1, mie_i=010, irq_timer_i=1 -> mcause=0x80000007, mtval=0, redirect 0x801C, tcu_kind_o=01.
- Simultaneous: irq_ext_i+irq_sw_i enabled plus lsu_trap_i=01 -> ext wins, mcause=0x8000000B, mepc=trap_pc_i; with MIE=0 -> load misaligned, mcause=0x4.
- MRET: enc_trap_i=10, mepc_i=0x2040 -> csr_mret_o pulse at +2, no csr_save_o, redirect 0x2040; ECALL+LSU_MISALIG_STORE together -> mcause=0xB.
- Backpressure: redirect_ready_i=0 for 5 cycles -> redirect_valid_o/pc held, stall_o=1, new irq ignored; accept -> IDLE, then pending irq taken.
- Reset asserted during SAVE -> all outputs 0 immediately, no csr_save_o; after release, valid_i=0 with traps asserted -> no action.
